// File: rtl/bb_uart_txp.sv
// -----------------------------------------------------------------------------
// bb_uart_txp -- asynchronous serial (UART-style) transmitter.
//
// Sends one frame per accepted request: start bit (0), DATA_BITS data bits
// LSB first, an optional parity bit, then STOP_BITS stop bits (1). Every bit
// is held for CLKS_PER_BIT cycles of bdclk. All outputs are registered.
//
// Ports:
//   bdclk   in   1          clock, all logic on the rising edge
//   rst     in   1          synchronous reset, active high
//   txen    in   1          transmit request, sampled every cycle
//   txreg   in   DATA_BITS  frame data, latched when the request is accepted
//   txd     out  1          serial line, idles high
//   txbsy   out  1          high while a frame is on the line
//   txdone  out  1          one-cycle pulse on the cycle after the last stop bit
//
// Configuration macro: BB_UART_TXP_PARITY_EN
//   defined   : PARITY selects 0 none / 1 odd / 2 even, parity bit after data
//   undefined : no parity hardware is built and PARITY has no effect
// -----------------------------------------------------------------------------
module bb_uart_txp #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                 bdclk,
  input  logic                 rst,
  input  logic                 txen,
  input  logic [DATA_BITS-1:0] txreg,
  output logic                 txd,
  output logic                 txbsy,
  output logic                 txdone
);

  // Divider only has to reach CLKS_PER_BIT-1; keep at least one bit.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Bit counter indexes data bits (up to 7) and stop bits (up to 1).
  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if ((DATA_BITS < 5) || (DATA_BITS > 8) || (CLKS_PER_BIT < 1) ||
      (STOP_BITS < 1) || (STOP_BITS > 2) || (PARITY < 0) || (PARITY > 2))
  begin : g_bad_cfg
    $error("bb_uart_txp: illegal parameter combination");
  end

`ifdef BB_UART_TXP_PARITY_EN
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  logic par_q;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_q;
  logic [DIV_W-1:0]       div_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   txd_q;
  logic                   txbsy_q;
  logic                   txdone_q;

  logic bit_end_d;
  logic last_stop_d;
  logic load_d;

  assign bit_end_d   = (div_q == '0);
  assign last_stop_d = (state_q == STOP) && bit_end_d && (bitcnt_q == LAST_STOP);
  // A request is taken when idle, or on the edge that ends the last stop bit
  // so that consecutive frames abut with no idle bit between them.
  assign load_d      = txen && ((state_q == IDLE) || last_stop_d);

  always_ff @(posedge bdclk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      txbsy_q  <= 1'b0;
      txdone_q <= 1'b0;
`ifdef BB_UART_TXP_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      txdone_q <= 1'b0;
      if (load_d) begin
        state_q  <= START;
        div_q    <= DIV_LOAD;
        bitcnt_q <= '0;
        shreg_q  <= txreg;
        txd_q    <= 1'b0;
        txbsy_q  <= 1'b1;
        // Frame end and next start coincide: still report the finished frame.
        if (state_q == STOP) txdone_q <= 1'b1;
`ifdef BB_UART_TXP_PARITY_EN
        // Even parity is the XOR of the data; odd parity is its inverse.
        par_q    <= (^txreg) ^ (PARITY == 1);
`endif
      end else if (state_q != IDLE) begin
        if (!bit_end_d) begin
          div_q <= div_q - 1'b1;
        end else begin
          div_q <= DIV_LOAD;
          case (state_q)
            START: begin
              state_q  <= DATA;
              bitcnt_q <= '0;
              txd_q    <= shreg_q[0];
              shreg_q  <= shreg_q >> 1;
            end
            DATA: begin
              if (bitcnt_q == LAST_DATA) begin
                bitcnt_q <= '0;
`ifdef BB_UART_TXP_PARITY_EN
                if (HAS_PAR) begin
                  state_q <= PAR;
                  txd_q   <= par_q;
                end else
`endif
                begin
                  state_q <= STOP;
                  txd_q   <= 1'b1;
                end
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
                txd_q    <= shreg_q[0];
                shreg_q  <= shreg_q >> 1;
              end
            end
            PAR: begin
              state_q  <= STOP;
              bitcnt_q <= '0;
              txd_q    <= 1'b1;
            end
            STOP: begin
              if (bitcnt_q == LAST_STOP) begin
                state_q  <= IDLE;
                txbsy_q  <= 1'b0;
                txdone_q <= 1'b1;
                txd_q    <= 1'b1;
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= IDLE;
              txbsy_q <= 1'b0;
              txd_q   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign txd    = txd_q;
  assign txbsy  = txbsy_q;
  assign txdone = txdone_q;

endmodule

// File: tb/tb_bb_uart_txp.sv
// -----------------------------------------------------------------------------
// tb_bb_uart_txp -- directed bench for bb_uart_txp.
// Instance A: 8 data bits, 4 clocks/bit, 1 stop, no parity.
// Instance B: 5 data bits, 1 clock/bit, 2 stops.
// Instances E/O (parity build only): even / odd parity, 2 clocks/bit.
// -----------------------------------------------------------------------------
module tb_bb_uart_txp;

  logic bdclk;
  logic rst;

  logic       txen_a, txd_a, bsy_a, done_a;
  logic [7:0] txreg_a;
  logic       txen_b, txd_b, bsy_b, done_b;
  logic [4:0] txreg_b;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  bb_uart_txp #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY(0)) u_a (
    .bdclk(bdclk), .rst(rst), .txen(txen_a), .txreg(txreg_a),
    .txd(txd_a), .txbsy(bsy_a), .txdone(done_a));

  bb_uart_txp #(.DATA_BITS(5), .CLKS_PER_BIT(1), .STOP_BITS(2), .PARITY(0)) u_b (
    .bdclk(bdclk), .rst(rst), .txen(txen_b), .txreg(txreg_b),
    .txd(txd_b), .txbsy(bsy_b), .txdone(done_b));

`ifdef BB_UART_TXP_PARITY_EN
  logic       txen_p, txd_e, bsy_e, done_e, txd_o, bsy_o, done_o;
  logic [7:0] txreg_p;

  bb_uart_txp #(.DATA_BITS(8), .CLKS_PER_BIT(2), .STOP_BITS(1), .PARITY(2)) u_e (
    .bdclk(bdclk), .rst(rst), .txen(txen_p), .txreg(txreg_p),
    .txd(txd_e), .txbsy(bsy_e), .txdone(done_e));

  bb_uart_txp #(.DATA_BITS(8), .CLKS_PER_BIT(2), .STOP_BITS(1), .PARITY(1)) u_o (
    .bdclk(bdclk), .rst(rst), .txen(txen_p), .txreg(txreg_p),
    .txd(txd_o), .txbsy(bsy_o), .txdone(done_o));
`endif

  initial bdclk = 1'b0;
  always #5 bdclk = ~bdclk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge bdclk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    txen_a  = 1'b1;            // must be ignored while in reset
    txreg_a = 8'hAA;
    txen_b  = 1'b0;
    txreg_b = 5'h00;
`ifdef BB_UART_TXP_PARITY_EN
    txen_p  = 1'b0;
    txreg_p = 8'h00;
`endif
    tick();
    tick();
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL reset_a: got %b want 100", {txd_a, bsy_a, done_a});
    end
    chk_cnt++;
    if ({txd_b, bsy_b, done_b} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL reset_b: got %b want 100", {txd_b, bsy_b, done_b});
    end
    rst    = 1'b0;
    txen_a = 1'b0;
    tick();
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL reset_release_a: got %b want 100", {txd_a, bsy_a, done_a});
    end
  endtask

  // 0x55 at 4 clocks/bit: 40 busy cycles, done on cycle 41.
  task automatic test_frame_55();
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    txen_a  = 1'b1;
    txreg_a = 8'h55;
    tick();
    txen_a  = 1'b0;
    txreg_a = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== {fr[(c-1)/4], 2'b10}) begin
        fail_cnt++;
        $display("FAIL frame55 cycle %0d: got %b want %b", c,
                 {txd_a, bsy_a, done_a}, {fr[(c-1)/4], 2'b10});
      end
      tick();
    end
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b101) begin
      fail_cnt++;
      $display("FAIL frame55 done: got %b want 101", {txd_a, bsy_a, done_a});
    end
    tick();
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL frame55 after: got %b want 100", {txd_a, bsy_a, done_a});
    end
  endtask

  // Request with 0xFF during a 0xA5 frame must not disturb it or queue.
  task automatic test_ignore_busy();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    txen_a  = 1'b1;
    txreg_a = 8'hA5;
    tick();
    txen_a  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin txen_a = 1'b1; txreg_a = 8'hFF; end
      if (c == 20) begin txen_a = 1'b0; end
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== {fr[(c-1)/4], 2'b10}) begin
        fail_cnt++;
        $display("FAIL ignore_busy cycle %0d: got %b want %b", c,
                 {txd_a, bsy_a, done_a}, {fr[(c-1)/4], 2'b10});
      end
      tick();
    end
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b101) begin
      fail_cnt++;
      $display("FAIL ignore_busy done: got %b want 101", {txd_a, bsy_a, done_a});
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== 3'b100) begin
        fail_cnt++;
        $display("FAIL ignore_busy idle %0d: got %b want 100", c, {txd_a, bsy_a, done_a});
      end
    end
  endtask

  // txen held: 0x31 then 0x32, second start bit lands on the done cycle.
  task automatic test_back_to_back();
    logic [9:0] f1;
    logic [9:0] f2;
    f1 = {1'b1, 8'h31, 1'b0};
    f2 = {1'b1, 8'h32, 1'b0};
    txen_a  = 1'b1;
    txreg_a = 8'h31;
    tick();
    txreg_a = 8'h32;             // latched copy of 0x31 must be unaffected
    for (int c = 1; c <= 40; c++) begin
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== {f1[(c-1)/4], 2'b10}) begin
        fail_cnt++;
        $display("FAIL b2b f1 cycle %0d: got %b want %b", c,
                 {txd_a, bsy_a, done_a}, {f1[(c-1)/4], 2'b10});
      end
      tick();
    end
    txen_a = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== {f2[(c-1)/4], 1'b1, (c == 1)}) begin
        fail_cnt++;
        $display("FAIL b2b f2 cycle %0d: got %b want %b", c,
                 {txd_a, bsy_a, done_a}, {f2[(c-1)/4], 1'b1, (c == 1)});
      end
      tick();
    end
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b101) begin
      fail_cnt++;
      $display("FAIL b2b done2: got %b want 101", {txd_a, bsy_a, done_a});
    end
    tick();
  endtask

  // Reset during data bit 3 aborts without txdone; next frame is clean.
  task automatic test_reset_midframe();
    logic [9:0] fr;
    fr = {1'b1, 8'h3C, 1'b0};
    txen_a  = 1'b1;
    txreg_a = 8'h55;
    tick();
    txen_a  = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    chk_cnt++;
    if ({txd_a, bsy_a} !== 2'b01) begin   // data bit 3 of 0x55 is 0
      fail_cnt++;
      $display("FAIL rst_mid pre: got %b want 01", {txd_a, bsy_a});
    end
    rst = 1'b1;
    tick();
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL rst_mid abort: got %b want 100", {txd_a, bsy_a, done_a});
    end
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      tick();
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== 3'b100) begin
        fail_cnt++;
        $display("FAIL rst_mid quiet %0d: got %b want 100", c, {txd_a, bsy_a, done_a});
      end
    end
    txen_a  = 1'b1;
    txreg_a = 8'h3C;
    tick();
    txen_a  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      chk_cnt++;
      if ({txd_a, bsy_a, done_a} !== {fr[(c-1)/4], 2'b10}) begin
        fail_cnt++;
        $display("FAIL rst_mid new cycle %0d: got %b want %b", c,
                 {txd_a, bsy_a, done_a}, {fr[(c-1)/4], 2'b10});
      end
      tick();
    end
    chk_cnt++;
    if ({txd_a, bsy_a, done_a} !== 3'b101) begin
      fail_cnt++;
      $display("FAIL rst_mid new done: got %b want 101", {txd_a, bsy_a, done_a});
    end
    tick();
  endtask

  // 5 data bits, 2 stop bits, 1 clock/bit: 0,1,1,1,1,1,1,1 then done.
  task automatic test_5n2();
    logic [7:0] fr;
    fr = {2'b11, 5'h1F, 1'b0};
    txen_b  = 1'b1;
    txreg_b = 5'h1F;
    tick();
    txen_b  = 1'b0;
    txreg_b = 5'h00;
    for (int c = 1; c <= 8; c++) begin
      chk_cnt++;
      if ({txd_b, bsy_b, done_b} !== {fr[c-1], 2'b10}) begin
        fail_cnt++;
        $display("FAIL 5n2 cycle %0d: got %b want %b", c,
                 {txd_b, bsy_b, done_b}, {fr[c-1], 2'b10});
      end
      tick();
    end
    chk_cnt++;
    if ({txd_b, bsy_b, done_b} !== 3'b101) begin
      fail_cnt++;
      $display("FAIL 5n2 done: got %b want 101", {txd_b, bsy_b, done_b});
    end
    tick();
    chk_cnt++;
    if ({txd_b, bsy_b, done_b} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL 5n2 after: got %b want 100", {txd_b, bsy_b, done_b});
    end
  endtask

`ifdef BB_UART_TXP_PARITY_EN
  // 0x07 has three ones: even parity bit 1, odd parity bit 0; 22 busy cycles.
  task automatic test_parity();
    logic [10:0] fe;
    logic [10:0] fo;
    fe = {1'b1, 1'b1, 8'h07, 1'b0};
    fo = {1'b1, 1'b0, 8'h07, 1'b0};
    txen_p  = 1'b1;
    txreg_p = 8'h07;
    tick();
    txen_p  = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      chk_cnt++;
      if ({txd_e, bsy_e, done_e} !== {fe[(c-1)/2], 2'b10}) begin
        fail_cnt++;
        $display("FAIL parity_even cycle %0d: got %b want %b", c,
                 {txd_e, bsy_e, done_e}, {fe[(c-1)/2], 2'b10});
      end
      chk_cnt++;
      if ({txd_o, bsy_o, done_o} !== {fo[(c-1)/2], 2'b10}) begin
        fail_cnt++;
        $display("FAIL parity_odd cycle %0d: got %b want %b", c,
                 {txd_o, bsy_o, done_o}, {fo[(c-1)/2], 2'b10});
      end
      tick();
    end
    chk_cnt++;
    if ({txd_e, bsy_e, done_e, txd_o, bsy_o, done_o} !== 6'b101101) begin
      fail_cnt++;
      $display("FAIL parity done: got %b want 101101",
               {txd_e, bsy_e, done_e, txd_o, bsy_o, done_o});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_frame_55();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_5n2();
`ifdef BB_UART_TXP_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
